prga_decrypt: RTL and testbench

// - RC4 keystream stage (PRGA): reads back the S array that the key-schedule shuffle left in S RAM.
// - Generates one pad byte per message byte and XORs it with ciphertext from the ct ROM.
// - Writes the length-prefixed plaintext to the pt RAM.
// - Sits after the shuffle stage under the top-level controller, using the same start/fsm_on/fin_strobe handshake.

---
 rtl/prga_decrypt.sv | 151 +++++++++++++++
 tb/tb_prga_decrypt.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_decrypt.sv
// RC4 keystream (PRGA) stage: walks the shuffled S array, swaps, fetches the pad
// byte and writes the length-prefixed plaintext ct ^ pad into the pt RAM.
module prga_decrypt #(
  parameter int MSG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        s_rdata,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  input  logic [7:0]        ct_rdata,
  output logic [MSG_AW-1:0] ct_addr,
  output logic [MSG_AW-1:0] pt_addr,
  output logic [7:0]        pt_wrdata,
  output logic              pt_wren,
  output logic              fsm_on,
  output logic              fin_strobe
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] RD_LEN  = 4'd1;
  localparam logic [3:0] CAP_LEN = 4'd2;
  localparam logic [3:0] RD_I    = 4'd3;
  localparam logic [3:0] CAP_I   = 4'd4;
  localparam logic [3:0] RD_J    = 4'd5;
  localparam logic [3:0] CAP_J   = 4'd6;
  localparam logic [3:0] WR_I    = 4'd7;
  localparam logic [3:0] WR_J    = 4'd8;
  localparam logic [3:0] RD_PAD  = 4'd9;
  localparam logic [3:0] WR_PT   = 4'd10;
  localparam logic [3:0] DONE    = 4'd11;

  localparam logic [7:0] LEN_MAX = 8'((1 << MSG_AW) - 1);

  // Longest message the ct ROM / pt RAM can hold bounds the length byte.
  function automatic logic [7:0] sat_len(input logic [7:0] v);
    if (v > LEN_MAX) return LEN_MAX;
    return v;
  endfunction

  logic [3:0]        state;
  logic [7:0]        i, j, si, sj, ct_q;
  logic [MSG_AW-1:0] k, len;
  logic [7:0]        len_sat;

  assign len_sat = sat_len(ct_rdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      ct_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i     <= '0;
            j     <= '0;
            k     <= MSG_AW'(1);
            state <= RD_LEN;
          end
        end
        RD_LEN:  state <= CAP_LEN;
        CAP_LEN: begin
          len   <= len_sat[MSG_AW-1:0];
          i     <= 8'd1;
          state <= (len_sat == 8'd0) ? DONE : RD_I;
        end
        RD_I:    state <= CAP_I;
        CAP_I: begin
          si    <= s_rdata;
          ct_q  <= ct_rdata;
          j     <= j + s_rdata;
          state <= RD_J;
        end
        RD_J:    state <= CAP_J;
        CAP_J: begin
          sj    <= s_rdata;
          state <= WR_I;
        end
        WR_I:    state <= WR_J;
        WR_J:    state <= RD_PAD;
        RD_PAD:  state <= WR_PT;
        WR_PT: begin
          if (k == len) begin
            state <= DONE;
          end else begin
            k     <= k + 1'b1;
            i     <= i + 8'd1;
            state <= RD_I;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while rst is high so an abort issues no write in its own cycle.
  always_comb begin
    s_addr     = '0;
    s_wrdata   = '0;
    s_wren     = 1'b0;
    ct_addr    = '0;
    pt_addr    = '0;
    pt_wrdata  = '0;
    pt_wren    = 1'b0;
    fsm_on     = 1'b0;
    fin_strobe = 1'b0;
    if (!rst) begin
      fsm_on = (state != IDLE);
      case (state)
        CAP_LEN: begin
          pt_wrdata = len_sat;
          pt_wren   = 1'b1;
        end
        RD_I: begin
          s_addr  = i;
          ct_addr = k;
        end
        RD_J:   s_addr = j;
        WR_I: begin
          s_addr   = i;
          s_wrdata = sj;
          s_wren   = 1'b1;
        end
        WR_J: begin
          s_addr   = j;
          s_wrdata = si;
          s_wren   = 1'b1;
        end
        RD_PAD: s_addr = si + sj;
        WR_PT: begin
          pt_addr   = k;
          pt_wrdata = s_rdata ^ ct_q;
          pt_wren   = 1'b1;
        end
        DONE:   fin_strobe = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: directed vector table, software RC4 reference with
// random keys and messages, start-while-busy and mid-run reset sequences.
module tb_prga_decrypt;
  localparam int AW = 5;
  localparam int LMAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    s_rdata, s_addr, s_wrdata;
  logic          s_wren;
  logic [7:0]    ct_rdata;
  logic [AW-1:0] ct_addr, pt_addr;
  logic [7:0]    pt_wrdata;
  logic          pt_wren, fsm_on, fin_strobe;

  logic [7:0] s_mem [256];
  logic [7:0] s_init [256];
  logic [7:0] ct_mem [32];
  logic [7:0] pt_mem [32];
  logic       load = 1'b0;
  int         s_wr_tot = 0;
  int         pt_wr_tot = 0;

  int total = 0;
  int bad = 0;

  int m_s [256];
  int m_pt [32];
  int m_len;

  prga_decrypt #(.MSG_AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_rdata(s_rdata), .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_rdata(ct_rdata), .ct_addr(ct_addr),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren),
    .fsm_on(fsm_on), .fin_strobe(fin_strobe)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; load reinstalls S and clears the pt RAM.
  always @(posedge clk) begin
    s_rdata  <= s_mem[s_addr];
    ct_rdata <= ct_mem[ct_addr];
    if (load) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
      for (int a = 0; a < 32; a++) pt_mem[a] <= 8'h00;
    end else begin
      if (s_wren) begin
        s_mem[s_addr] <= s_wrdata;
        s_wr_tot <= s_wr_tot + 1;
      end
      if (pt_wren) begin
        pt_mem[pt_addr] <= pt_wrdata;
        pt_wr_tot <= pt_wr_tot + 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic s_identity();
    for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
  endtask

  task automatic ksa(input int keylen);
    int key [8];
    int jj;
    int t;
    for (int a = 0; a < keylen; a++) key[a] = int'($urandom_range(0, 255));
    s_identity();
    jj = 0;
    for (int a = 0; a < 256; a++) begin
      jj = (jj + int'(s_init[a]) + key[a % keylen]) % 256;
      t = int'(s_init[a]);
      s_init[a] = s_init[jj];
      s_init[jj] = 8'(t);
    end
  endtask

  // Plain RC4 PRGA over a copy of the installed S.
  task automatic model();
    int ii, jj, t;
    m_len = (int'(ct_mem[0]) > LMAX) ? LMAX : int'(ct_mem[0]);
    for (int a = 0; a < 256; a++) m_s[a] = int'(s_init[a]);
    for (int a = 0; a < 32; a++) m_pt[a] = 0;
    m_pt[0] = m_len;
    ii = 0;
    jj = 0;
    for (int n = 1; n <= m_len; n++) begin
      ii = (ii + 1) % 256;
      jj = (jj + m_s[ii]) % 256;
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
      m_pt[n] = int'(ct_mem[n]) ^ m_s[(m_s[ii] + m_s[jj]) % 256];
    end
  endtask

  task automatic prep();
    @(posedge clk);
    #1 load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic run(input bit noisy, output int cyc);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    while (cyc < 600 && !fin_strobe) begin
      start = (noisy && cyc >= 4 && cyc <= 9);
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    if (!fin_strobe) begin
      chk("fin_timeout", cyc, -1);
    end else begin
      @(posedge clk);
      #1;
      chk("fin_one_cycle", int'(fin_strobe), 0);
      chk("idle_after_done", int'(fsm_on), 0);
    end
  endtask

  typedef struct {
    logic [7:0] ct0, ct1, ct2;
    logic [7:0] p0, p1, p2;
    int         cyc;
    logic [7:0] s2, s3;
    int         swr;
  } vec_t;

  vec_t tbl [3];

  task automatic cmp_model(input string tag);
    int pm, sm;
    pm = 0;
    sm = 0;
    for (int a = 0; a <= m_len; a++) if (int'(pt_mem[a]) != m_pt[a]) pm++;
    for (int a = 0; a < 256; a++) if (int'(s_mem[a]) != m_s[a]) sm++;
    chk({tag, "_pt_mismatches"}, pm, 0);
    chk({tag, "_s_mismatches"}, sm, 0);
  endtask

  initial begin
    int cyc, sw0, pw0, len;
    for (int a = 0; a < 32; a++) ct_mem[a] = 8'h00;
    s_identity();

    tbl[0] = '{8'h01, 8'h41, 8'h00, 8'h01, 8'h43, 8'h00, 11, 8'h02, 8'h03, 2};
    tbl[1] = '{8'h02, 8'h41, 8'h00, 8'h02, 8'h43, 8'h05, 19, 8'h03, 8'h02, 4};
    tbl[2] = '{8'h00, 8'h55, 8'h66, 8'h00, 8'h00, 8'h00, 3, 8'h02, 8'h03, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_fsm_on", int'(fsm_on), 0);
    chk("rst_fin", int'(fin_strobe), 0);
    chk("rst_s_wren", int'(s_wren), 0);
    chk("rst_pt_wren", int'(pt_wren), 0);
    chk("rst_s_addr", int'(s_addr), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_fsm_on", int'(fsm_on), 0);

    for (int v = 0; v < 3; v++) begin
      s_identity();
      ct_mem[0] = tbl[v].ct0;
      ct_mem[1] = tbl[v].ct1;
      ct_mem[2] = tbl[v].ct2;
      prep();
      sw0 = s_wr_tot;
      pw0 = pt_wr_tot;
      run(1'b0, cyc);
      chk($sformatf("v%0d_cycles", v), cyc, tbl[v].cyc);
      chk($sformatf("v%0d_pt0", v), int'(pt_mem[0]), int'(tbl[v].p0));
      chk($sformatf("v%0d_pt1", v), int'(pt_mem[1]), int'(tbl[v].p1));
      chk($sformatf("v%0d_pt2", v), int'(pt_mem[2]), int'(tbl[v].p2));
      chk($sformatf("v%0d_s2", v), int'(s_mem[2]), int'(tbl[v].s2));
      chk($sformatf("v%0d_s3", v), int'(s_mem[3]), int'(tbl[v].s3));
      chk($sformatf("v%0d_s_writes", v), s_wr_tot - sw0, tbl[v].swr);
      chk($sformatf("v%0d_pt_writes", v), pt_wr_tot - pw0, int'(tbl[v].ct0) + 1);
    end

    // Oversized length byte saturates to the RAM depth.
    s_identity();
    ct_mem[0] = 8'hFF;
    for (int a = 1; a < 32; a++) ct_mem[a] = 8'($urandom_range(0, 255));
    prep();
    model();
    pw0 = pt_wr_tot;
    run(1'b0, cyc);
    chk("clamp_pt0", int'(pt_mem[0]), 8'h1F);
    chk("clamp_pt_data_writes", pt_wr_tot - pw0 - 1, 31);
    chk("clamp_cycles", cyc, 3 + 8 * LMAX);
    cmp_model("clamp");

    // Random keys; the last pass also waves start around mid-run.
    for (int r = 0; r < 5; r++) begin
      ksa(int'($urandom_range(3, 8)));
      len = int'($urandom_range(1, LMAX));
      ct_mem[0] = 8'(len);
      for (int a = 1; a < 32; a++) ct_mem[a] = 8'($urandom_range(0, 255));
      prep();
      model();
      pw0 = pt_wr_tot;
      run(r == 4, cyc);
      chk($sformatf("rnd%0d_cycles", r), cyc, 3 + 8 * len);
      chk($sformatf("rnd%0d_pt_writes", r), pt_wr_tot - pw0, len + 1);
      cmp_model($sformatf("rnd%0d", r));
    end

    // Abort with rst while the first swap write is on the bus.
    s_identity();
    ct_mem[0] = 8'h03;
    prep();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("pre_abort_s_wren", int'(s_wren), 1);
    rst = 1'b1;
    #1;
    chk("abort_s_wren", int'(s_wren), 0);
    chk("abort_fsm_on", int'(fsm_on), 0);
    chk("abort_s_addr", int'(s_addr), 0);
    sw0 = s_wr_tot;
    pw0 = pt_wr_tot;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_s_writes", s_wr_tot - sw0, 0);
    chk("abort_no_pt_writes", pt_wr_tot - pw0, 0);
    chk("abort_idle", int'(fsm_on), 0);

    s_identity();
    ct_mem[0] = 8'h01;
    ct_mem[1] = 8'h41;
    prep();
    run(1'b0, cyc);
    chk("rerun_cycles", cyc, 11);
    chk("rerun_pt1", int'(pt_mem[1]), 8'h43);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
